// File: rtl/branch_resolve_unit.sv
// Registered EX-stage branch resolver. It compares the forwarded operands, checks the
// outcome against the fetch prediction, and keeps a 2-bit BHT plus perf counters.
module branch_resolve_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BHT_DEPTH  = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   output logic                  lookup_taken,
   input  logic                  res_valid,
   input  logic                  branch,
   input  logic [2:0]            branchType,
   input  logic [DATA_WIDTH-1:0] read1,
   input  logic [DATA_WIDTH-1:0] read2,
   input  logic                  read1_forward,
   input  logic                  read2_forward,
   input  logic [DATA_WIDTH-1:0] read1_forward_val,
   input  logic [DATA_WIDTH-1:0] read2_forward_val,
   input  logic [ADDR_WIDTH-1:0] res_pc,
   input  logic [ADDR_WIDTH-1:0] res_target,
   input  logic                  res_pred_taken,
   output logic                  out_valid,
   output logic                  taken,
   output logic                  mispredict,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  illegal_type,
   output logic [CNT_WIDTH-1:0]  branch_count,
   output logic [CNT_WIDTH-1:0]  mispredict_count
);
   localparam int IDX_W = $clog2(BHT_DEPTH);

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_RSV2 = 3'b010;
   localparam logic [2:0] F3_RSV3 = 3'b011;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   logic [DATA_WIDTH-1:0] op1;
   logic [DATA_WIDTH-1:0] op2;
   logic                  cond;
   logic                  capture;
   logic                  taken_next;
   logic                  mispredict_next;
   logic                  illegal_next;
   logic [ADDR_WIDTH-1:0] redirect_next;

   logic                  out_valid_reg;
   logic                  taken_reg;
   logic                  mispredict_reg;
   logic                  illegal_reg;
   logic [ADDR_WIDTH-1:0] redirect_reg;
   logic [CNT_WIDTH-1:0]  branch_cnt_reg;
   logic [CNT_WIDTH-1:0]  mispredict_cnt_reg;

   logic [1:0]            bht_q [BHT_DEPTH];
   logic [IDX_W-1:0]      res_idx;
   logic [IDX_W-1:0]      lookup_idx;
   logic                  bht_update;
   logic                  unused_lookup;

   assign op1 = read1_forward ? read1_forward_val : read1;
   assign op2 = read2_forward ? read2_forward_val : read2;

   always_comb begin
      cond         = 1'b0;
      illegal_next = 1'b0;
      if (branch) begin
         case (branchType)
            F3_BEQ:           cond = (op1 == op2);
            F3_BNE:           cond = (op1 != op2);
            F3_BLT:           cond = ($signed(op1) < $signed(op2));
            F3_BGE:           cond = ($signed(op1) >= $signed(op2));
            F3_BLTU:          cond = (op1 < op2);
            F3_BGEU:          cond = (op1 >= op2);
            F3_RSV2, F3_RSV3: illegal_next = 1'b1;
            default:          cond = 1'b0;
         endcase
      end
   end

   // cond is already forced low for non-branches, so it doubles as the taken outcome.
   assign capture         = res_valid & ~stall & ~flush;
   assign taken_next      = branch & cond;
   assign mispredict_next = branch & (taken_next ^ res_pred_taken);
   assign redirect_next   = taken_next ? res_target : (res_pc + ADDR_WIDTH'(4));

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         out_valid_reg  <= 1'b0;
         taken_reg      <= 1'b0;
         mispredict_reg <= 1'b0;
         illegal_reg    <= 1'b0;
         redirect_reg   <= '0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else if (!stall) begin
         out_valid_reg <= res_valid;
         if (res_valid) begin
            taken_reg      <= taken_next;
            mispredict_reg <= mispredict_next;
            illegal_reg    <= illegal_next;
            redirect_reg   <= redirect_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         branch_cnt_reg     <= '0;
         mispredict_cnt_reg <= '0;
      end else begin
         if (capture && branch) begin
            branch_cnt_reg <= branch_cnt_reg + CNT_WIDTH'(1);
         end
         if (capture && mispredict_next) begin
            mispredict_cnt_reg <= mispredict_cnt_reg + CNT_WIDTH'(1);
         end
      end
   end

   assign out_valid        = out_valid_reg;
   assign taken            = taken_reg;
   assign mispredict       = mispredict_reg & out_valid_reg;
   assign redirect_pc      = redirect_reg;
   assign illegal_type     = illegal_reg;
   assign branch_count     = branch_cnt_reg;
   assign mispredict_count = mispredict_cnt_reg;

   // Both ports index the BHT by word address; upper PC bits simply alias.
   assign res_idx       = res_pc[IDX_W+1:2];
   assign lookup_idx    = lookup_pc[IDX_W+1:2];
   assign bht_update    = capture & branch & ~illegal_next;
   assign unused_lookup = ^lookup_pc;

   genvar gi;
   generate
      for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
         logic [1:0] ctr_reg;
         logic [1:0] ctr_next;
         logic       hit;

         assign hit = bht_update && (res_idx == IDX_W'(gi));

         always_comb begin
            ctr_next = ctr_reg;
            if (hit) begin
               if (taken_next) begin
                  if (ctr_reg != 2'b11) ctr_next = ctr_reg + 2'b01;
               end else begin
                  if (ctr_reg != 2'b00) ctr_next = ctr_reg - 2'b01;
               end
            end
         end

         always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) ctr_reg <= 2'b01;
            else       ctr_reg <= ctr_next;
         end

         assign bht_q[gi] = ctr_reg;
      end
   endgenerate

   // Lookup reads the current counter; a same-cycle update is not bypassed.
   assign lookup_taken = bht_q[lookup_idx][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed scoreboard bench for branch_resolve_unit with an
// arithmetic reference model of resolution, BHT counters and perf counters.
module tb_branch_resolve_unit;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BD = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic [AW-1:0] lookup_pc = '0;
   logic          lookup_taken;
   logic          res_valid = 1'b0;
   logic          branch = 1'b0;
   logic [2:0]    branchType = 3'b000;
   logic [DW-1:0] read1 = '0;
   logic [DW-1:0] read2 = '0;
   logic          read1_forward = 1'b0;
   logic          read2_forward = 1'b0;
   logic [DW-1:0] read1_forward_val = '0;
   logic [DW-1:0] read2_forward_val = '0;
   logic [AW-1:0] res_pc = '0;
   logic [AW-1:0] res_target = '0;
   logic          res_pred_taken = 1'b0;
   logic          out_valid;
   logic          taken;
   logic          mispredict;
   logic [AW-1:0] redirect_pc;
   logic          illegal_type;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   always #5 clk = ~clk;

   branch_resolve_unit #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BHT_DEPTH(BD), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rstN(rstN), .stall(stall), .flush(flush),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
      .res_valid(res_valid), .branch(branch), .branchType(branchType),
      .read1(read1), .read2(read2),
      .read1_forward(read1_forward), .read2_forward(read2_forward),
      .read1_forward_val(read1_forward_val), .read2_forward_val(read2_forward_val),
      .res_pc(res_pc), .res_target(res_target), .res_pred_taken(res_pred_taken),
      .out_valid(out_valid), .taken(taken), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .illegal_type(illegal_type),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   typedef struct {
      int          cyc;
      logic        tk;
      logic        mp;
      logic        ill;
      logic [31:0] rpc;
      logic [3:0]  bc;
      logic [3:0]  mc;
   } exp_t;

   exp_t       q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   logic [1:0] bht_m [16];
   logic [3:0] bc_m = '0;
   logic [3:0] mc_m = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Branch outcome from the ISA rules using wide integer arithmetic.
   function automatic void ref_resolve(input logic br, input logic [2:0] ft,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic tk, output logic ill);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      tk  = 1'b0;
      ill = 1'b0;
      if (br) begin
         case (ft)
            3'd0: tk = (ua == ub);
            3'd1: tk = (ua != ub);
            3'd2, 3'd3: ill = 1'b1;
            3'd4: tk = (sa < sb);
            3'd5: tk = (sa >= sb);
            3'd6: tk = (ua < ub);
            default: tk = (ua >= ub);
         endcase
      end
   endfunction

   task automatic drive(input logic rv, input logic br, input logic [2:0] ft,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic fw1, input logic [31:0] fv1,
                        input logic fw2, input logic [31:0] fv2,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] lpc,
                        input logic pred, input logic st, input logic fl);
      logic [31:0] a, b;
      logic        tk, ill, mp, cap;
      exp_t        e;
      int          idx, v;
      @(posedge clk);
      #1;
      res_valid = rv; branch = br; branchType = ft; read1 = r1; read2 = r2;
      read1_forward = fw1; read1_forward_val = fv1; read2_forward = fw2; read2_forward_val = fv2;
      res_pc = pc; res_target = tgt; lookup_pc = lpc; res_pred_taken = pred;
      stall = st; flush = fl;
      a = fw1 ? fv1 : r1;
      b = fw2 ? fv2 : r2;
      ref_resolve(br, ft, a, b, tk, ill);
      cap = rv && !st && !fl;
      mp  = br && (tk != pred);
      if (cap) begin
         if (br) bc_m = bc_m + 4'd1;
         if (mp) mc_m = mc_m + 4'd1;
         e.cyc = cyc + 1; e.tk = tk; e.mp = mp; e.ill = ill;
         e.rpc = tk ? tgt : pc + 32'd4;
         e.bc = bc_m; e.mc = mc_m;
         q.push_back(e);
      end
      #1;
      chk("lookup_taken", 32'(lookup_taken), 32'(bht_m[lpc[5:2]][1]));
      if (cap && br && !ill) begin
         idx = int'(pc[5:2]);
         v   = int'(bht_m[idx]);
         if (tk) v = (v == 3) ? 3 : v + 1;
         else    v = (v == 0) ? 0 : v - 1;
         bht_m[idx] = 2'(v);
      end
   endtask

   task automatic idle(input logic [31:0] lpc);
      drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, lpc, 0, 0, 0);
   endtask

   task automatic rand_cycle();
      logic [31:0] r1, r2, pc, lpc;
      r2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r1  = ($urandom_range(0, 2) == 0) ? r2 : $urandom;
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {22'd0, 8'($urandom), 2'b00};
      lpc = ($urandom_range(0, 1) == 0) ? pc : {$urandom_range(0, 65535), 2'b00};
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 6) != 0, 3'($urandom),
            r1, r2, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0, r1,
            pc, {$urandom, 2'b00}, lpc, 1'($urandom),
            $urandom_range(0, 6) == 0, $urandom_range(0, 13) == 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rstN = 1'b0; res_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_branch_count", 32'(branch_count), 32'd0);
      chk("async_rst_mispredict_count", 32'(mispredict_count), 32'd0);
      for (int i = 0; i < 16; i++) begin
         lookup_pc = ($urandom & 32'hFFFF_FFC0) | 32'(i * 4);
         #1;
         chk("rst_lookup_taken", 32'(lookup_taken), 32'd0);
      end
      for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
      bc_m = '0;
      mc_m = '0;
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   // Monitor: pops one expectation whenever a fresh result should be presented.
   initial begin
      exp_t last;
      logic ev, st, fl;
      ev = 1'b0;
      last = '{default: 0};
      forever begin
         @(posedge clk);
         st = stall;
         fl = flush;
         @(negedge clk);
         if (!rstN) begin
            q.delete();
            last = '{default: 0};
            ev = 1'b0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_taken", 32'(taken), 32'd0);
            chk("rst_mispredict", 32'(mispredict), 32'd0);
            chk("rst_illegal_type", 32'(illegal_type), 32'd0);
            chk("rst_redirect_pc", redirect_pc, 32'd0);
            chk("rst_branch_count", 32'(branch_count), 32'd0);
            chk("rst_mispredict_count", 32'(mispredict_count), 32'd0);
         end else begin
            if (fl) begin
               ev = 1'b0;
            end else if (!st) begin
               ev = (q.size() > 0) && (q[0].cyc == cyc);
               if (ev) begin
                  last = q.pop_front();
                  $display("txn cyc=%0d taken=%0b mispredict=%0b redirect=%h illegal=%0b bc=%0d mc=%0d",
                           cyc, last.tk, last.mp, last.rpc, last.ill, last.bc, last.mc);
               end
            end
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) chk("mispredict", 32'(mispredict), 32'(last.mp));
            chk("taken", 32'(taken), 32'(last.tk));
            chk("redirect_pc", redirect_pc, last.rpc);
            chk("illegal_type", 32'(illegal_type), 32'(last.ill));
            chk("branch_count", 32'(branch_count), 32'(last.bc));
            chk("mispredict_count", 32'(mispredict_count), 32'(last.mc));
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
      do_reset();

      // Signed vs unsigned compare of -1 against 1
      drive(1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 32'h1000, 32'h2000, 32'h1000, 0, 0, 0);
      drive(1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 32'h1004, 32'h2000, 32'h1004, 0, 0, 0);
      idle(32'h0);

      // Forwarded operand makes BEQ taken against a not-taken prediction
      do_reset();
      drive(1, 1, 3'b000, 32'd5, 32'd7, 0, 0, 1, 32'd5, 32'h200, 32'h100, 32'h200, 0, 0, 0);
      idle(32'h200);

      // BHT saturation, aliasing and same-cycle lookup of the updating entry
      for (int i = 0; i < 3; i++)
         drive(1, 1, 3'b000, 32'd9, 32'd9, 0, 0, 0, 0, 32'h40, 32'h300, 32'h40, 1, 0, 0);
      idle(32'h40);
      idle(32'h80);
      drive(1, 1, 3'b000, 32'd9, 32'd8, 0, 0, 0, 0, 32'h40, 32'h300, 32'h40, 1, 0, 0);
      idle(32'h40);

      // Stall holds everything, stalled requests are dropped, flush beats stall
      drive(1, 1, 3'b001, 32'd1, 32'd2, 0, 0, 0, 0, 32'h500, 32'h600, 32'h500, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         drive(1, 1, 3'b000, 32'd3, 32'd3, 0, 0, 0, 0, 32'h500, 32'h700, 32'h500, 0, 1, 0);
      drive(1, 1, 3'b000, 32'd3, 32'd3, 0, 0, 0, 0, 32'h500, 32'h700, 32'h500, 0, 1, 1);
      idle(32'h500);

      // Reserved func3 values: not taken, flagged, no BHT change, still counted
      drive(1, 1, 3'b010, 32'd4, 32'd4, 0, 0, 0, 0, 32'h40, 32'h800, 32'h40, 1, 0, 0);
      drive(1, 1, 3'b011, 32'd4, 32'd5, 0, 0, 0, 0, 32'h40, 32'h800, 32'h40, 0, 0, 0);
      drive(1, 0, 3'b100, 32'd1, 32'd5, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h800, 32'h40, 1, 0, 0);
      idle(32'h40);

      for (int i = 0; i < 250; i++) rand_cycle();
      do_reset();
      for (int i = 0; i < 120; i++) rand_cycle();

      // Sixteen branches wrap a 4-bit branch counter back to zero
      do_reset();
      for (int i = 0; i < 16; i++)
         drive(1, 1, 3'($urandom), $urandom, $urandom, 0, 0, 0, 0,
               {24'd0, 6'(i), 2'b00}, 32'h900, 32'h0, 1'($urandom), 0, 0);
      idle(32'h0);
      @(negedge clk);
      chk("wrap_branch_count", 32'(branch_count), 32'd0);

      repeat (3) idle(32'h0);
      @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised, registered successor to the combinational branch comparator in the EX stage. It resolves conditional branches with operand forwarding, registers the outcome, and compares it against the fetch-stage prediction. It keeps a BHT of 2-bit saturating counters that the fetch stage reads, drives redirect/mispredict to the pipeline control, and keeps performance counters.

Parameters:
DATA_WIDTH, 32, operand width for comparison
ADDR_WIDTH, 32, PC/target width
BHT_DEPTH, 16, BHT entries; power of 2, at least 2; IDX_W = log2(BHT_DEPTH)
CNT_WIDTH, 32, width of each perf counter

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
stall  in  1  hold output register and BHT; ignore res_valid
flush  in  1  kill the in-flight resolve
lookup_pc  in  ADDR_WIDTH  fetch PC for prediction
lookup_taken  out  1  combinational prediction (counter MSB)
res_valid  in  1  resolve request valid
branch  in  1  instruction is a conditional branch
branchType  in  3  func3
read1, read2  in  DATA_WIDTH  register-file operands
read1_forward, read2_forward  in  1  forwarding selects
read1_forward_val, read2_forward_val  in  DATA_WIDTH  forwarded operands
res_pc  in  ADDR_WIDTH  branch PC
res_target  in  ADDR_WIDTH  computed branch target
res_pred_taken  in  1  prediction used at fetch for this branch
out_valid  out  1  registered result valid
taken  out  1  branch resolved taken
mispredict  out  1  taken != res_pred_taken; qualified by out_valid
redirect_pc  out  ADDR_WIDTH  correct next PC
illegal_type  out  1  branch with func3 010/011
branch_count  out  CNT_WIDTH  resolved branches
mispredict_count  out  CNT_WIDTH  mispredictions

Behaviour:
- Reset (async, rstN=0): out_valid, taken, mispredict, illegal_type = 0. redirect_pc = 0. Both counters = 0. Every BHT entry = 2'b01 (weakly not-taken).
- Operand select: opX = readX_forward ? readX_forward_val : readX.
- Compare by func3:
  - 000 BEQ: eq
  - 001 BNE: ne
  - 100 BLT: signed <
  - 101 BGE: signed >=
  - 110 BLTU: unsigned <
  - 111 BGEU: unsigned >=
  - 010/011: not taken; illegal_type = 1.
  - branch=0: cond = 0, illegal_type = 0.
- Capture = res_valid & ~stall & ~flush. Latency is 1 cycle: results appear at the clock edge after capture.
- On capture, the register takes:
  - out_valid = 1
  - taken = branch & cond
  - mispredict = branch & (taken ^ res_pred_taken)
  - redirect_pc = taken ? res_target : res_pc + 4 (modulo 2^ADDR_WIDTH)
- Non-branch capture (branch=0): out_valid = 1, taken = 0, mispredict = 0, redirect_pc = res_pc + 4.
- No capture and stall=0: out_valid = 0. Other output fields hold their last values.
- stall=1 and flush=0: all registers hold, including out_valid. The BHT and counters do not update.
- flush=1: out_valid = 0 next edge, regardless of stall or res_valid. flush has priority over stall.
- BHT index = pc[IDX_W+1:2] for both lookup_pc and res_pc. lookup_taken = entry[idx][1].
- BHT update on a capture with branch=1 and illegal_type=0:
  - taken: saturating increment, stop at 11
  - not taken: saturating decrement, stop at 00
- Lookup and update on the same index in the same cycle: lookup returns the pre-update value. There is no bypass.
- branch_count: +1 on each capture with branch=1, including illegal types.
- mispredict_count: +1 on each capture with a mispredict.
- Both counters wrap modulo 2^CNT_WIDTH.
- Reset mid-operation clears all state immediately. There is no pending update.

Test Plan:
- Reset: rstN=0 mid-run -> all outputs 0; lookup_taken=0 for every index; counters=0.
- BLT/BLTU sign: read1=32'hFFFF_FFFF, read2=1. BLT (100) -> taken=1. BLTU (110) -> taken=0, redirect_pc=res_pc+4. Both are valid one cycle after capture.
- Forwarding + mispredict: BEQ, read1=5, read2=7, read2_forward=1, read2_forward_val=5, res_pred_taken=0, res_target=32'h100 -> taken=1, mispredict=1, redirect_pc=32'h100, mispredict_count=1.
- BHT saturation: res_pc=32'h40, three taken BEQs -> entry reaches 11, lookup_taken=1 for lookup_pc=32'h40 (and aliases such as 32'h80 when BHT_DEPTH=16). Then one not-taken -> 10, lookup still 1. Same-cycle lookup on the updating index returns the old value.
- Stall/flush: capture, then stall=1 for 3 cycles -> out_valid and fields held, and a res_valid during the stall is ignored. flush=1 with stall=1 -> out_valid=0 next edge; the BHT and counters are unchanged.
- Illegal/wrap: branchType=010 -> taken=0, illegal_type=1, BHT unchanged, branch_count+1. With CNT_WIDTH=4, 16 branches -> branch_count wraps to 0.
